// File: rtl/hs_ram_arbiter_if.sv
// Bus bundle between the CPU decode, the hiscore engine, the core pause logic and the work RAM.
// The arbiter takes the slave side; the surrounding system (or a bench) takes the master side.
interface hs_ram_arbiter_if #(
  parameter int AW = 10
) ();
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_we;
  logic [7:0]    cpu_rdata;
  logic          hs_access;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_wdata;
  logic          hs_we;
  logic [7:0]    hs_rdata;
  logic          hs_grant;
  logic          hs_denied;
  logic          pause_req;
  logic          pause_ack;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_q;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, hs_access, hs_addr, hs_wdata, hs_we, pause_ack, ram_q,
    output cpu_rdata, hs_rdata, hs_grant, hs_denied, pause_req, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, hs_access, hs_addr, hs_wdata, hs_we, pause_ack, ram_q,
    input  cpu_rdata, hs_rdata, hs_grant, hs_denied, pause_req, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Shares the single-port game work RAM between the CPU and the hiscore engine by pausing
// the CPU, waiting for its acknowledge plus a settle delay, then granting the port to the engine.
module hs_ram_arbiter #(
  parameter int          AW             = 10,
  parameter logic [7:0]  SETTLE_CYCLES  = 8'd4,
  parameter logic [7:0]  RELEASE_CYCLES = 8'd2,
  parameter logic [15:0] ACK_TIMEOUT    = 16'hFFFF
) (
  input  logic           clk,
  input  logic           reset,
  hs_ram_arbiter_if.slave bus,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAUSE   = 3'd1,
    SETTLE  = 3'd2,
    GRANT   = 3'd3,
    RELEASE = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [15:0] tmo_cnt;

  assign state_dbg     = state;
  assign bus.cpu_rdata = bus.ram_q;

  // Handshakes are level based: the engine holds hs_access for the whole transaction and owns
  // the port exactly while hs_grant=1; the core holds pause_ack while the CPU is halted and
  // pause_req stays high until the port has been handed back.
  always_comb begin
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_we    = bus.cpu_we;
    case (state)
      SETTLE, RELEASE: begin
        bus.ram_addr  = bus.hs_addr;
        bus.ram_wdata = bus.hs_wdata;
        bus.ram_we    = 1'b0;
      end
      GRANT: begin
        bus.ram_addr  = bus.hs_addr;
        bus.ram_wdata = bus.hs_wdata;
        // Engine writes die with its release and with reset, without waiting for an edge.
        bus.ram_we    = bus.hs_we & bus.hs_access & reset;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      tmo_cnt       <= 16'd0;
      bus.hs_grant  <= 1'b0;
      bus.pause_req <= 1'b0;
      bus.hs_denied <= 1'b0;
      bus.hs_rdata  <= 8'd0;
    end else begin
      bus.hs_denied <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hs_access) begin
            state         <= PAUSE;
            bus.pause_req <= 1'b1;
            tmo_cnt       <= 16'd0;
          end
        end
        PAUSE: begin
          if (!bus.hs_access) begin
            state <= RELEASE;
            cnt   <= 8'd0;
          end else if (bus.pause_ack) begin
            if (SETTLE_CYCLES == 8'd0) begin
              state        <= GRANT;
              bus.hs_grant <= 1'b1;
            end else begin
              state <= SETTLE;
              cnt   <= 8'd0;
            end
          end else if (tmo_cnt + 16'd1 == ACK_TIMEOUT) begin
            state         <= LOCKOUT;
            bus.pause_req <= 1'b0;
            bus.hs_denied <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        SETTLE: begin
          if (!bus.hs_access) begin
            state <= RELEASE;
            cnt   <= 8'd0;
          end else if (!bus.pause_ack) begin
            state   <= PAUSE;
            tmo_cnt <= 16'd0;
          end else if (cnt + 8'd1 == SETTLE_CYCLES) begin
            state        <= GRANT;
            bus.hs_grant <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GRANT: begin
          bus.hs_rdata <= bus.ram_q;
          if (!bus.hs_access) begin
            state        <= RELEASE;
            bus.hs_grant <= 1'b0;
            cnt          <= 8'd0;
          end
        end
        RELEASE: begin
          if (cnt + 8'd1 >= RELEASE_CYCLES) begin
            state         <= IDLE;
            bus.pause_req <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LOCKOUT: begin
          if (!bus.hs_access) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter: grant sequence, engine write/read, release, ack timeout,
// ack glitch during settle and reset in the middle of a grant.
module tb_hs_ram_arbiter;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PAUSE   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_GRANT   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_LOCKOUT = 3'd5;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mem [0:1023] = '{default: 8'h00};

  hs_ram_arbiter_if #(.AW(10)) bus ();

  hs_ram_arbiter #(
    .AW(10), .SETTLE_CYCLES(8'd4), .RELEASE_CYCLES(8'd2), .ACK_TIMEOUT(16'd16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // 1-cycle synchronous RAM, read-old-data on a same-address write
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_q <= mem[bus.ram_addr];
  end

  // driver: inputs change 1 time unit after the rising edge, checks follow 1 unit later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_we = 1'b0;
    bus.hs_access = 1'b0; bus.hs_addr = '0; bus.hs_wdata = '0; bus.hs_we = 1'b0;
    bus.pause_ack = 1'b0;
    repeat (2) next_cycle();
    bus.cpu_we = 1'b1; bus.cpu_addr = 10'h005; bus.cpu_wdata = 8'h11;
    #1;
    n_cmp++; if (state_dbg !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
    n_cmp++; if (bus.hs_grant !== 1'b0) begin n_err++; $display("FAIL reset_grant: got %b expected 0", bus.hs_grant); end
    n_cmp++; if (bus.pause_req !== 1'b0) begin n_err++; $display("FAIL reset_pause_req: got %b expected 0", bus.pause_req); end
    n_cmp++; if (bus.hs_denied !== 1'b0) begin n_err++; $display("FAIL reset_denied: got %b expected 0", bus.hs_denied); end
    n_cmp++; if (bus.hs_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h expected 00", bus.hs_rdata); end
    n_cmp++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h005) begin
      n_err++; $display("FAIL reset_cpu_path: got we=%b addr=%h expected we=1 addr=005", bus.ram_we, bus.ram_addr);
    end
    bus.cpu_we = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic_grant();
    logic exp_pr, exp_gr, exp_we;
    logic [9:0] exp_addr;
    for (int c = 0; c <= 9; c++) begin
      next_cycle();
      bus.hs_access = 1'b1;
      bus.hs_addr   = 10'h3F0;
      bus.pause_ack = (c >= 3);
      bus.cpu_we    = (c == 2) || (c >= 4 && c <= 8);
      bus.cpu_addr  = 10'(c);
      #1;
      exp_pr   = (c >= 1);
      exp_gr   = (c >= 8);
      exp_we   = (c < 4) ? bus.cpu_we : 1'b0;
      exp_addr = (c < 4) ? 10'(c) : 10'h3F0;
      n_cmp++; if (bus.pause_req !== exp_pr) begin n_err++; $display("FAIL basic_pause_req c=%0d: got %b expected %b", c, bus.pause_req, exp_pr); end
      n_cmp++; if (bus.hs_grant !== exp_gr) begin n_err++; $display("FAIL basic_grant c=%0d: got %b expected %b", c, bus.hs_grant, exp_gr); end
      n_cmp++; if (bus.ram_we !== exp_we) begin n_err++; $display("FAIL basic_ram_we c=%0d: got %b expected %b", c, bus.ram_we, exp_we); end
      n_cmp++; if (bus.ram_addr !== exp_addr) begin n_err++; $display("FAIL basic_ram_addr c=%0d: got %h expected %h", c, bus.ram_addr, exp_addr); end
    end
  endtask

  task automatic test_engine_rw();
    // write cycle; CPU strobe must not leak through
    next_cycle();
    bus.hs_addr = 10'h3F0; bus.hs_wdata = 8'hA5; bus.hs_we = 1'b1; bus.cpu_we = 1'b1;
    #1;
    n_cmp++; if (bus.ram_we !== 1'b1 || bus.ram_wdata !== 8'hA5 || bus.ram_addr !== 10'h3F0) begin
      n_err++; $display("FAIL rw_write: got we=%b data=%h addr=%h expected we=1 data=a5 addr=3f0", bus.ram_we, bus.ram_wdata, bus.ram_addr);
    end
    // read address cycle
    next_cycle();
    bus.hs_we = 1'b0;
    #1;
    n_cmp++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL rw_no_cpu_we: got %b expected 0", bus.ram_we); end
    next_cycle();
    bus.hs_addr = 10'h000; bus.cpu_we = 1'b0;
    #1;
    n_cmp++; if (bus.hs_rdata !== 8'h00) begin n_err++; $display("FAIL rw_rdata_early: got %h expected 00", bus.hs_rdata); end
    n_cmp++; if (bus.cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL rw_cpu_rdata: got %h expected a5", bus.cpu_rdata); end
    next_cycle();
    #1;
    n_cmp++; if (bus.hs_rdata !== 8'hA5) begin n_err++; $display("FAIL rw_rdata: got %h expected a5", bus.hs_rdata); end
  endtask

  task automatic test_release();
    next_cycle();
    bus.hs_access = 1'b0; bus.hs_we = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h155;
    #1;
    n_cmp++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL rel_we_ignored: got %b expected 0", bus.ram_we); end
    n_cmp++; if (bus.hs_grant !== 1'b1) begin n_err++; $display("FAIL rel_grant_hold: got %b expected 1", bus.hs_grant); end
    next_cycle();
    bus.hs_we = 1'b0;
    #1;
    n_cmp++; if (bus.hs_grant !== 1'b0) begin n_err++; $display("FAIL rel_grant_drop: got %b expected 0", bus.hs_grant); end
    n_cmp++; if (state_dbg !== S_RELEASE || bus.ram_we !== 1'b0 || bus.pause_req !== 1'b1) begin
      n_err++; $display("FAIL rel_muted: got state=%0d we=%b pr=%b expected state=4 we=0 pr=1", state_dbg, bus.ram_we, bus.pause_req);
    end
    next_cycle();
    #1;
    n_cmp++; if (bus.pause_req !== 1'b1) begin n_err++; $display("FAIL rel_pr_hold: got %b expected 1", bus.pause_req); end
    next_cycle();
    #1;
    n_cmp++; if (bus.pause_req !== 1'b0) begin n_err++; $display("FAIL rel_pr_drop: got %b expected 0", bus.pause_req); end
    n_cmp++; if (bus.ram_addr !== 10'h155 || bus.ram_we !== 1'b1) begin
      n_err++; $display("FAIL rel_cpu_back: got addr=%h we=%b expected addr=155 we=1", bus.ram_addr, bus.ram_we);
    end
    bus.cpu_we = 1'b0; bus.pause_ack = 1'b0;
  endtask

  task automatic test_ack_timeout();
    logic exp_pr, exp_dn;
    for (int c = 0; c <= 27; c++) begin
      next_cycle();
      bus.hs_access = (c <= 20) || (c == 22) || (c == 23);
      bus.pause_ack = 1'b0;
      bus.cpu_we    = (c == 19);
      #1;
      exp_pr = (c >= 1 && c <= 16) || (c >= 23 && c <= 26);
      exp_dn = (c == 17);
      n_cmp++; if (bus.pause_req !== exp_pr) begin n_err++; $display("FAIL tmo_pause_req c=%0d: got %b expected %b", c, bus.pause_req, exp_pr); end
      n_cmp++; if (bus.hs_denied !== exp_dn) begin n_err++; $display("FAIL tmo_denied c=%0d: got %b expected %b", c, bus.hs_denied, exp_dn); end
      n_cmp++; if (bus.hs_grant !== 1'b0) begin n_err++; $display("FAIL tmo_grant c=%0d: got %b expected 0", c, bus.hs_grant); end
      if (c == 19) begin
        n_cmp++; if (state_dbg !== S_LOCKOUT || bus.ram_we !== 1'b1) begin
          n_err++; $display("FAIL tmo_lockout_cpu: got state=%0d we=%b expected state=5 we=1", state_dbg, bus.ram_we);
        end
      end
    end
  endtask

  task automatic test_ack_glitch();
    logic exp_gr;
    for (int c = 0; c <= 11; c++) begin
      next_cycle();
      bus.hs_access = 1'b1;
      bus.pause_ack = (c == 1) || (c == 2) || (c >= 5);
      #1;
      exp_gr = (c >= 10);
      n_cmp++; if (bus.hs_grant !== exp_gr) begin n_err++; $display("FAIL glitch_grant c=%0d: got %b expected %b", c, bus.hs_grant, exp_gr); end
      if (c == 2 || c == 4) begin
        n_cmp++; if (state_dbg !== ((c == 2) ? S_SETTLE : S_PAUSE)) begin
          n_err++; $display("FAIL glitch_state c=%0d: got %0d expected %0d", c, state_dbg, (c == 2) ? S_SETTLE : S_PAUSE);
        end
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    next_cycle();
    reset = 1'b0; bus.hs_we = 1'b1; bus.hs_addr = 10'h2AA; bus.cpu_we = 1'b0;
    #1;
    n_cmp++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL rst_cut_we: got %b expected 0", bus.ram_we); end
    next_cycle();
    reset = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h00F; bus.hs_access = 1'b0; bus.hs_we = 1'b0;
    #1;
    n_cmp++; if (bus.hs_grant !== 1'b0 || bus.pause_req !== 1'b0) begin
      n_err++; $display("FAIL rst_outputs: got grant=%b pr=%b expected 0 0", bus.hs_grant, bus.pause_req);
    end
    n_cmp++; if (state_dbg !== S_IDLE || bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h00F) begin
      n_err++; $display("FAIL rst_cpu_path: got state=%0d we=%b addr=%h expected 0 1 00f", state_dbg, bus.ram_we, bus.ram_addr);
    end
    bus.cpu_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_grant();
    test_engine_rw();
    test_release();
    test_ack_timeout();
    test_ack_glitch();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares one single-port game work RAM between the game CPU and the hiscore save/restore engine.
- When the engine raises its access request, the arbiter asks the core to pause the CPU and waits for the pause acknowledge plus a settle delay. It then grants the RAM port to the engine and hands the port back after the engine releases.
- Sits between the CPU bus decode and the RAM instance, alongside the hiscore engine.

Parameters:
- AW, 10, game RAM address width.
- SETTLE_CYCLES, 4, cycles after pause_ack before grant (8-bit counter; 0 allowed).
- RELEASE_CYCLES, 2, cycles the port stays muted after engine release before the CPU regains ownership (8-bit counter).
- ACK_TIMEOUT, 16'hFFFF, maximum cycles to wait for pause_ack before aborting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_rdata  out  8  RAM read data to CPU (combinational pass of ram_q).
- hs_access  in  1  engine requests RAM (level, held for the whole transaction).
- hs_addr  in  AW  engine address.
- hs_wdata  in  8  engine write data.
- hs_we  in  1  engine write strobe.
- hs_rdata  out  8  registered read data to engine.
- hs_grant  out  1  engine owns RAM port.
- hs_denied  out  1  one-cycle pulse: request aborted on ack timeout.
- pause_req  out  1  request to core to halt the CPU.
- pause_ack  in  1  core confirms the CPU is halted.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  8  RAM read data (1-cycle synchronous RAM).

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; counters=0.
  - hs_grant=0, pause_req=0, hs_denied=0, hs_rdata=0, lockout=0.
- States: IDLE, PAUSE, SETTLE, GRANT, RELEASE, LOCKOUT.
- IDLE:
  - The CPU owns the port: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we.
  - hs_access=1 -> PAUSE, pause_req<=1, timeout counter<=0.
- PAUSE:
  - The CPU mux stays selected.
  - pause_ack=1 -> SETTLE, settle counter<=0.
  - Otherwise the counter increments. At count==ACK_TIMEOUT: pause_req<=0, hs_denied<=1 for one cycle, -> LOCKOUT.
  - hs_access dropping in PAUSE -> RELEASE. The engine is never granted.
- SETTLE:
  - The port is muted: ram_we=0, ram_addr=hs_addr.
  - When the counter reaches SETTLE_CYCLES -> GRANT, hs_grant<=1.
  - With SETTLE_CYCLES=0, grant occurs on the first cycle after pause_ack is seen.
  - pause_ack dropping in SETTLE -> back to PAUSE, timeout counter restarts.
- GRANT:
  - The engine owns the port: ram_addr=hs_addr, ram_wdata=hs_wdata, ram_we=hs_we.
  - hs_rdata<=ram_q every cycle. Read latency is 2 clocks from hs_addr to hs_rdata (RAM + register).
  - hs_access=0 -> RELEASE, hs_grant<=0. An hs_we on that same cycle is ignored (ram_we=0).
  - pause_ack dropping during GRANT is ignored. The arbiter never preempts the engine.
- RELEASE:
  - The port is muted (ram_we=0), pause_req stays 1.
  - After RELEASE_CYCLES -> IDLE, pause_req<=0.
- LOCKOUT:
  - The CPU owns the port.
  - Stays until hs_access=0, then -> IDLE. This prevents immediate retry storms.
- The CPU write strobe is forwarded only in IDLE, PAUSE and LOCKOUT. cpu_we is never forwarded in SETTLE, GRANT or RELEASE.
- A reset mid-GRANT returns the port to the CPU on the next edge; ram_we from the engine is cut immediately.
- hs_denied and hs_grant are never high on the same cycle.

Test Plan:
- Basic grant, SETTLE_CYCLES=4:
  - Stimulus: hs_access=1 at cycle 0, pause_ack=1 at cycle 3.
  - Response: pause_req=1 from cycle 1, hs_grant=1 at cycle 8, cpu_we pulses in cycles 4-8 not seen on ram_we.
- Engine write/read:
  - Stimulus: in GRANT, write 8'hA5 to addr 10'h3F0, then read 10'h3F0.
  - Response: ram_we=1 one cycle with ram_wdata=8'hA5; hs_rdata=8'hA5 two cycles after the read address.
- Release:
  - Stimulus: hs_access=0 in GRANT, RELEASE_CYCLES=2.
  - Response: hs_grant=0 next cycle, pause_req=0 three cycles later, CPU address back on ram_addr.
- Ack timeout, ACK_TIMEOUT=16:
  - Stimulus: pause_ack held at 0.
  - Response: hs_denied single pulse after 16 PAUSE cycles, pause_req=0; no new pause_req while hs_access stays 1; after it drops and rises again, pause_req reasserts.
- Ack glitch:
  - Stimulus: pause_ack drops during SETTLE.
  - Response: back to PAUSE with no grant; grant only after a full re-settle.
- Reset mid-transfer:
  - Stimulus: reset=0 during GRANT with hs_we=1.
  - Response: next edge hs_grant=0, pause_req=0, ram_we follows cpu_we.
